mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates icache fills and dcache reads/writes onto one shared RAM port.
// Latency: grant one cycle after the request is seen in IDLE; earliest completion is the first serve cycle.
// Backpressure: requesters see wait=1 until RAM reports ACCESS/ERROR; one IDLE cycle separates transactions.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   iREN/iaddr -> iwait/iload          icache read side
//   dREN/dWEN/daddr/dstore -> dwait/dload   dcache side (write wins if both set)
//   ramREN/ramWEN/ramaddr/ramstore <- ramload/ramstate   shared RAM port
//   err                      one-cycle pulse on RAM ERROR or serve timeout
// Build option: define MEM_ARB_ROUNDROBIN_EN for alternating grants on contention
// instead of dcache priority with a starvation counter.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Timer counts completed serve cycles, so the TIMEOUT-th cycle sees TIMEOUT-1.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] timer;
  logic       dreq;
  logic       idle;
  logic       owner_req;
  logic       live;
  logic       ram_done;
  logic       tmo;
  logic       grant_d;
  logic       grant_i;

  assign dreq = dREN | dWEN;
  assign idle = (state == IDLE);

  // The owning requester must still be asking; a dropped enable aborts silently.
  assign owner_req = ((state == SERVE_I) & iREN) | ((state == SERVE_D) & dreq);
  // Reset masks completion so no wait pulse escapes during a reset cycle.
  assign live      = owner_req & ~RST;
  assign ram_done  = live & ((ramstate == RAM_ACCESS) | (ramstate == RAM_ERROR));
  assign tmo       = live & ~ram_done & (timer == TIMER_LAST);

  assign iwait = ~(ram_done & (state == SERVE_I));
  assign dwait = ~(ram_done & (state == SERVE_D));
  assign err   = (ram_done & (ramstate == RAM_ERROR)) | tmo;
  assign iload = ramload;
  assign dload = ramload;

`ifdef MEM_ARB_ROUNDROBIN_EN
  // Remembers whether the last grant went to icache; reset as "I" so dcache wins first.
  logic last_i;

  assign grant_d = idle & dreq & (~iREN | last_i);

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_i <= 1'b1;
    end else if (grant_d) begin
      last_i <= 1'b0;
    end else if (grant_i) begin
      last_i <= 1'b1;
    end
  end
`else
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

  // Consecutive dcache grants taken while icache was waiting.
  logic [3:0] streak;

  assign grant_d = idle & dreq & ~(iREN & (streak == STREAK_MAX));

  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= '0;
    end else if (!iREN) begin
      streak <= '0;
    end else if (grant_d) begin
      if (streak != STREAK_MAX) begin
        streak <= streak + 4'd1;
      end
    end else if (grant_i) begin
      streak <= '0;
    end
  end
`endif

  assign grant_i = idle & iREN & ~grant_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
    end else if (idle) begin
      timer <= '0;
      if (grant_d) begin
        state    <= SERVE_D;
        ramREN   <= ~dWEN;
        ramWEN   <= dWEN;
        ramaddr  <= daddr;
        ramstore <= dstore;
      end else if (grant_i) begin
        state   <= SERVE_I;
        ramREN  <= 1'b1;
        ramWEN  <= 1'b0;
        ramaddr <= iaddr;
      end
    end else begin
      timer <= timer + 8'd1;
      if (!owner_req || ram_done || tmo) begin
        state  <= IDLE;
        ramREN <= 1'b0;
        ramWEN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (vector table plus corner-case sequences).
// Latency: expects grant one cycle after request, completion in the ACCESS/ERROR cycle.
// Backpressure: RAM side is modelled by driving ramstate BUSY/ACCESS/ERROR per transaction.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    int          busy;
    logic [31:0] rload;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Returns at the negedge of the first serve cycle (or after a bounded wait).
  task automatic wait_grant(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while (!(ramREN | ramWEN) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (!(ramREN | ramWEN)) begin
      bad++;
      $display("FAIL %s: no grant within 20 cycles got 0 expected 1", nm);
    end
  endtask

  // Called at a serve-cycle negedge; finishes the transaction with ACCESS.
  task automatic complete(input string nm, input logic side_d, input logic [31:0] rload);
    logic [31:0] exp_load;
    ramstate = S_ACCESS;
    ramload  = rload;
    #1;
    chk({nm, " owner wait"}, side_d ? dwait : iwait, 0);
    chk({nm, " other wait"}, side_d ? iwait : dwait, 1);
    chk({nm, " err"}, err, 0);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got 0 entries expected 1", nm);
    end else begin
      exp_load = sb.pop_front();
      chk({nm, " load"}, side_d ? dload : iload, exp_load);
    end
    @(posedge CLK);
    #1;
    ramstate = S_FREE;
  endtask

  logic exp_d[5];
  logic got_d;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 3, 32'hDEADBEEF, 1'b1, 1'b0, 32'h40};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h0, 0, 32'hCAFEF00D, 1'b1, 1'b0, 32'h200};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h100, 32'h1234, 1, 32'h0, 1'b0, 1'b1, 32'h100};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h300, 32'hA5A5, 2, 32'h0, 1'b0, 1'b1, 32'h300};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 2, 32'h13572468, 1'b1, 1'b0, 32'hFFFFFFFC};

`ifdef MEM_ARB_ROUNDROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

    RST = 1'b1; iREN = 1'b1; iaddr = 32'h80;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = S_FREE;

    // Reset held two cycles with iREN pending.
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk("reset iwait", iwait, 1);
      chk("reset dwait", dwait, 1);
      chk("reset ramREN", ramREN, 0);
      chk("reset err", err, 0);
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("post-reset ramREN", ramREN, 1);
    chk("post-reset ramaddr", ramaddr, 32'h80);
    sb.push_back(32'h11112222);
    complete("post-reset", 1'b0, 32'h11112222);
    iREN = 1'b0;

    // Single-transaction vector table.
    for (int v = 0; v < 5; v++) begin
      @(posedge CLK);
      #1;
      iREN = vecs[v].iren; iaddr = vecs[v].iaddr;
      dREN = vecs[v].dren; dWEN = vecs[v].dwen;
      daddr = vecs[v].daddr; dstore = vecs[v].dstore;
      sb.push_back(vecs[v].rload);
      wait_grant($sformatf("vec%0d grant", v));
      chk($sformatf("vec%0d ramREN", v), ramREN, vecs[v].exp_ren);
      chk($sformatf("vec%0d ramWEN", v), ramWEN, vecs[v].exp_wen);
      chk($sformatf("vec%0d ramaddr", v), ramaddr, vecs[v].exp_addr);
      if (vecs[v].exp_wen) chk($sformatf("vec%0d ramstore", v), ramstore, vecs[v].dstore);
      for (int b = 0; b < vecs[v].busy; b++) begin
        ramstate = S_BUSY;
        #1;
        chk($sformatf("vec%0d busy wait", v), vecs[v].iren ? iwait : dwait, 1);
        @(negedge CLK);
      end
      complete($sformatf("vec%0d", v), ~vecs[v].iren, vecs[v].rload);
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      @(negedge CLK);
      chk($sformatf("vec%0d enables drop", v), ramREN | ramWEN, 0);
      chk($sformatf("vec%0d iwait after", v), iwait, 1);
    end

    // Write priority over a simultaneous icache read, icache next.
    @(posedge CLK);
    #1;
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h1234;
    sb.push_back(32'h0);
    wait_grant("prio d grant");
    chk("prio ramWEN", ramWEN, 1);
    chk("prio ramaddr d", ramaddr, 32'h100);
    chk("prio ramstore", ramstore, 32'h1234);
    complete("prio d", 1'b1, 32'h0);
    dWEN = 1'b0;
    sb.push_back(32'h5555AAAA);
    wait_grant("prio i grant");
    chk("prio ramREN i", ramREN, 1);
    chk("prio ramaddr i", ramaddr, 32'h44);
    complete("prio i", 1'b0, 32'h5555AAAA);
    iREN = 1'b0;

    // Starvation / fairness with both sides continuously requesting.
    @(posedge CLK);
    #1;
    iREN = 1'b1; iaddr = 32'h500;
    dREN = 1'b1; daddr = 32'h600;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("starve grant%0d", g));
      got_d = (ramaddr == 32'h600);
      chk($sformatf("starve side%0d", g), got_d, exp_d[g]);
      sb.push_back(32'(g));
      complete($sformatf("starve%0d", g), got_d, 32'(g));
    end
    iREN = 1'b0; dREN = 1'b0;

    // Timeout with RAM stuck BUSY.
    @(posedge CLK);
    #1;
    dREN = 1'b1; daddr = 32'h700;
    ramstate = S_BUSY;
    wait_grant("tmo grant");
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("tmo err c%0d", k), err, (k == 8) ? 1 : 0);
      chk($sformatf("tmo dwait c%0d", k), dwait, 1);
      if (k < 8) @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    ramstate = S_FREE;
    @(negedge CLK);
    chk("tmo ramREN idle", ramREN, 0);
    chk("tmo err idle", err, 0);

    // RAM ERROR response.
    @(posedge CLK);
    #1;
    dREN = 1'b1; daddr = 32'h710;
    wait_grant("error grant");
    ramstate = S_ERROR;
    #1;
    chk("error dwait", dwait, 0);
    chk("error err", err, 1);
    chk("error iwait", iwait, 1);
    @(posedge CLK);
    #1;
    dREN = 1'b0;
    ramstate = S_FREE;
    @(negedge CLK);
    chk("error ramREN idle", ramREN, 0);
    chk("error err idle", err, 0);

    // Abort: dcache drops its request mid-serve, pending icache then served.
    @(posedge CLK);
    #1;
    dREN = 1'b1; daddr = 32'h900;
    wait_grant("abort grant");
    chk("abort ramaddr", ramaddr, 32'h900);
    ramstate = S_BUSY;
    iREN = 1'b1; iaddr = 32'h800;
    @(negedge CLK);
    dREN = 1'b0;
    #1;
    chk("abort dwait", dwait, 1);
    chk("abort err", err, 0);
    @(negedge CLK);
    chk("abort ramREN drop", ramREN, 0);
    chk("abort dwait idle", dwait, 1);
    ramstate = S_FREE;
    @(negedge CLK);
    chk("abort i grant", ramREN, 1);
    chk("abort i ramaddr", ramaddr, 32'h800);
    sb.push_back(32'hABCD0123);
    complete("abort i", 1'b0, 32'hABCD0123);
    iREN = 1'b0;

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
